// File: rtl/lag_traffic_sink_pkg.sv
// Shared types and helpers for the LAG traffic sink.
//   flit_t       : ejected flit (control, ids, debug/inject metadata)
//   sink_state_t : per-channel packet reassembly state
//   sink_err_t   : error codes reported by the sink (0 = none)
package lag_traffic_sink_pkg;

  typedef struct packed {
    logic valid;
    logic head;
    logic tail;
  } flit_control_t;

  typedef struct packed {
    logic [3:0]  xdest;
    logic [3:0]  ydest;
    logic [31:0] inject_time;
  } flit_debug_t;

  typedef struct packed {
    flit_control_t control;
    logic [15:0]   packet_id;
    logic [7:0]    flit_id;
    flit_debug_t   debug;
  } flit_t;

  typedef enum logic {
    StIdle,
    StBody
  } sink_state_t;

  typedef enum logic [2:0] {
    ErrNone       = 3'd0,
    ErrNoHead     = 3'd1,
    ErrHeadInBody = 3'd2,
    ErrSeq        = 3'd3,
    ErrDest       = 3'd4,
    ErrPktId      = 3'd5,
    ErrNotReady   = 3'd6,
    ErrTailId     = 3'd7
  } sink_err_t;

  // Per-channel LFSR seed; forced odd so it is never the all-zero lock-up state.
  function automatic logic [15:0] lfsr_seed(input int unsigned idx);
    return 16'((idx + 32'd1) * 32'h1D3) | 16'h0001;
  endfunction

  // 16-bit maximal Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // ready is asserted when the 7-bit LFSR sample is at or above this value.
  function automatic int unsigned stall_threshold(input int unsigned pct);
    return (pct * 32'd128) / 32'd100;
  endfunction

endpackage

// File: rtl/lag_traffic_sink_pl_checker.sv
// Per-channel packet checker for the LAG traffic sink.
// Tracks one packet at a time on its channel: sequence of flit ids, packet id,
// destination and tail id, and reports completion or the error code.
//   clk, rst_n  : clock, synchronous active-low reset
//   accept      : this channel is selected and ready this cycle
//   flit        : the ejected flit (valid qualifies it together with accept)
//   complete    : packet finished this cycle
//   drop        : flit discarded (not counted as received)
//   err         : error code for this flit, ErrNone if clean
//   start_time  : inject_time of the completing packet
module lag_traffic_sink_pl_checker
  import lag_traffic_sink_pkg::*;
#(
  parameter int unsigned xpos          = 0,
  parameter int unsigned ypos          = 0,
  parameter int unsigned packet_length = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  flit_t       flit,
  output logic        complete,
  output logic        drop,
  output sink_err_t   err,
  output logic [31:0] start_time
);

  localparam logic [3:0] XPos   = 4'(xpos);
  localparam logic [3:0] YPos   = 4'(ypos);
  localparam logic [7:0] PktLen = 8'(packet_length);

  sink_state_t state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic [15:0] pid_q, pid_d;
  logic [31:0] inj_q, inj_d;

  logic take;
  logic dest_bad;
  logic tail_bad;

  assign take     = accept & flit.control.valid;
  assign dest_bad = (flit.debug.xdest != XPos) || (flit.debug.ydest != YPos);
  assign tail_bad = flit.control.tail && (flit.flit_id != PktLen);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      exp_q   <= 8'd0;
      pid_q   <= 16'd0;
      inj_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      pid_q   <= pid_d;
      inj_q   <= inj_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    pid_d      = pid_q;
    inj_d      = inj_q;
    complete   = 1'b0;
    drop       = 1'b0;
    err        = ErrNone;
    start_time = inj_q;

    if (take) begin
      if (flit.control.head) begin
        // A head in BODY abandons the old packet and is adopted as a new one.
        if (state_q == StBody) err = ErrHeadInBody;
        if (dest_bad || tail_bad) begin
          drop    = 1'b1;
          state_d = StIdle;
          if (err == ErrNone) err = dest_bad ? ErrDest : ErrTailId;
        end else if (flit.control.tail) begin
          complete   = 1'b1;
          start_time = flit.debug.inject_time;
          state_d    = StIdle;
        end else begin
          state_d = StBody;
          pid_d   = flit.packet_id;
          exp_d   = 8'd2;
          inj_d   = flit.debug.inject_time;
        end
      end else if (state_q == StIdle) begin
        err  = ErrNoHead;
        drop = 1'b1;
      end else begin
        if (dest_bad)                       err = ErrDest;
        else if (flit.packet_id != pid_q)   err = ErrPktId;
        else if (flit.flit_id != exp_q)     err = ErrSeq;
        else if (tail_bad)                  err = ErrTailId;

        if (err != ErrNone) begin
          drop    = 1'b1;
          state_d = StIdle;
        end else begin
          exp_d = exp_q + 8'd1;
          if (flit.control.tail) begin
            complete = 1'b1;
            state_d  = StIdle;
          end
        end
      end
    end
  end

endmodule

// File: rtl/lag_traffic_sink.sv
// LAG network traffic sink: accepts ejected flits, checks packet framing per
// channel, and keeps packet/flit/latency statistics plus a sticky first error.
// Back-pressure per channel comes from an LFSR compared against stall_pct.
//   clk, rst_n       : clock, synchronous active-low reset
//   flit_in, in_pl   : ejected flit and its channel index
//   ready            : registered per-channel sink-ready
//   packets_received : completed packets (mod 2^32)
//   flits_received   : accepted, non-dropped flits (mod 2^32)
//   latency_sum      : sum of packet latencies (mod 2^48)
//   latency_max      : largest packet latency
//   error/error_code : sticky error flag and the first error code
module lag_traffic_sink
  import lag_traffic_sink_pkg::*;
#(
  parameter int unsigned nv            = 4,
  parameter int unsigned xpos          = 0,
  parameter int unsigned ypos          = 0,
  parameter int unsigned packet_length = 3,
  parameter int unsigned stall_pct     = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  flit_t                                   flit_in,
  input  logic [((nv > 1) ? $clog2(nv) : 1)-1:0] in_pl,
  output logic [nv-1:0]                           ready,
  output logic [31:0]                             packets_received,
  output logic [31:0]                             flits_received,
  output logic [47:0]                             latency_sum,
  output logic [31:0]                             latency_max,
  output logic                                    error,
  output logic [2:0]                              error_code
);

  localparam int unsigned PlW    = (nv > 1) ? $clog2(nv) : 1;
  localparam int unsigned Thresh = stall_threshold(stall_pct);

  logic [31:0] sys_time_q;
  logic [nv-1:0] ready_q, ready_d;
  logic [31:0] pkts_q, flits_q, lat_max_q;
  logic [47:0] lat_sum_q;
  logic        error_q;
  logic [2:0]  error_code_q;

  logic          ready_sel;
  logic          accept;
  logic          not_ready;
  logic [nv-1:0] acc_v, complete_v, drop_v;
  sink_err_t     err_v   [nv];
  logic [31:0]   start_v [nv];

  logic        any_complete;
  logic        any_drop;
  logic [2:0]  err_or;
  logic [31:0] start_sel;
  logic [31:0] latency;
  logic [2:0]  cyc_err;

  // Out-of-range channel indices read as not-ready.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < int'(nv); i++) begin
      if (in_pl == PlW'(i)) ready_sel = ready_q[i];
    end
  end

  assign accept    = flit_in.control.valid & ready_sel;
  assign not_ready = flit_in.control.valid & ~ready_sel;

  for (genvar g = 0; g < int'(nv); g++) begin : gen_pl
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= lfsr_seed(g);
      else        lfsr_q <= lfsr_next(lfsr_q);
    end

    assign ready_d[g] = 32'(lfsr_q[6:0]) >= Thresh;
    assign acc_v[g]   = accept && (in_pl == PlW'(g));

    lag_traffic_sink_pl_checker #(
      .xpos          (xpos),
      .ypos          (ypos),
      .packet_length (packet_length)
    ) u_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (acc_v[g]),
      .flit       (flit_in),
      .complete   (complete_v[g]),
      .drop       (drop_v[g]),
      .err        (err_v[g]),
      .start_time (start_v[g])
    );
  end

  // Only the addressed channel can report anything, so OR-merging is exact.
  always_comb begin
    any_complete = |complete_v;
    any_drop     = |drop_v;
    err_or       = 3'd0;
    start_sel    = 32'd0;
    for (int i = 0; i < int'(nv); i++) begin
      err_or = err_or | 3'(err_v[i]);
      if (complete_v[i]) start_sel = start_sel | start_v[i];
    end
    latency = sys_time_q - start_sel;
    cyc_err = not_ready ? 3'(ErrNotReady) : err_or;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sys_time_q   <= 32'd0;
      ready_q      <= '0;
      pkts_q       <= 32'd0;
      flits_q      <= 32'd0;
      lat_sum_q    <= 48'd0;
      lat_max_q    <= 32'd0;
      error_q      <= 1'b0;
      error_code_q <= 3'd0;
    end else begin
      sys_time_q <= sys_time_q + 32'd1;
      ready_q    <= ready_d;
      if (accept && !any_drop) flits_q <= flits_q + 32'd1;
      if (any_complete) begin
        pkts_q    <= pkts_q + 32'd1;
        lat_sum_q <= lat_sum_q + {16'd0, latency};
        if (latency > lat_max_q) lat_max_q <= latency;
      end
      if (!error_q && (cyc_err != 3'd0)) begin
        error_q      <= 1'b1;
        error_code_q <= cyc_err;
      end
    end
  end

  assign ready            = ready_q;
  assign packets_received = pkts_q;
  assign flits_received   = flits_q;
  assign latency_sum      = lat_sum_q;
  assign latency_max      = lat_max_q;
  assign error            = error_q;
  assign error_code       = error_code_q;

endmodule

// File: tb/tb_lag_traffic_sink.sv
module tb_lag_traffic_sink;
  import lag_traffic_sink_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  flit_t       f0, f100, f50;
  logic [1:0]  pl0, pl100, pl50;

  logic [3:0]  rdy0, rdy100, rdy50;
  logic [31:0] pk0, pk100, pk50;
  logic [31:0] fl0, fl100, fl50;
  logic [47:0] ls0, ls100, ls50;
  logic [31:0] lm0, lm100, lm50;
  logic        er0, er100, er50;
  logic [2:0]  ec0, ec100, ec50;

  lag_traffic_sink #(.stall_pct(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flit_in(f0), .in_pl(pl0), .ready(rdy0),
    .packets_received(pk0), .flits_received(fl0), .latency_sum(ls0),
    .latency_max(lm0), .error(er0), .error_code(ec0)
  );

  lag_traffic_sink #(.stall_pct(100)) dut100 (
    .clk(clk), .rst_n(rst_n), .flit_in(f100), .in_pl(pl100), .ready(rdy100),
    .packets_received(pk100), .flits_received(fl100), .latency_sum(ls100),
    .latency_max(lm100), .error(er100), .error_code(ec100)
  );

  lag_traffic_sink #(.stall_pct(50)) dut50 (
    .clk(clk), .rst_n(rst_n), .flit_in(f50), .in_pl(pl50), .ready(rdy50),
    .packets_received(pk50), .flits_received(fl50), .latency_sum(ls50),
    .latency_max(lm50), .error(er50), .error_code(ec50)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(input logic [2:0] vht, input logic [15:0] pid,
                               input logic [7:0] fid, input logic [3:0] xd,
                               input logic [31:0] inj);
    flit_t f;
    f.control.valid     = vht[2];
    f.control.head      = vht[1];
    f.control.tail      = vht[0];
    f.packet_id         = pid;
    f.flit_id           = fid;
    f.debug.xdest       = xd;
    f.debug.ydest       = 4'd0;
    f.debug.inject_time = inj;
    return f;
  endfunction

  typedef struct {
    logic        rst;
    logic [2:0]  vht;
    logic [1:0]  pl;
    logic [15:0] pid;
    logic [7:0]  fid;
    logic [3:0]  xd;
    logic [31:0] inj;
    logic [31:0] e_fl;
    logic [31:0] e_pk;
    logic [47:0] e_ls;
    logic [31:0] e_lm;
    logic        e_er;
    logic [2:0]  e_ec;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic rst, input logic [2:0] vht, input logic [1:0] pl,
                               input logic [15:0] pid, input logic [7:0] fid,
                               input logic [3:0] xd, input logic [31:0] inj,
                               input logic [31:0] fl, input logic [31:0] pk,
                               input logic [47:0] ls, input logic [31:0] lm,
                               input logic er, input logic [2:0] ec);
    vec_t v;
    v.rst = rst; v.vht = vht; v.pl = pl; v.pid = pid; v.fid = fid; v.xd = xd;
    v.inj = inj; v.e_fl = fl; v.e_pk = pk; v.e_ls = ls; v.e_lm = lm;
    v.e_er = er; v.e_ec = ec;
    v.e_rdy = rst ? 4'h0 : 4'hF;
    return v;
  endfunction

  // Reset row followed by the idle cycle that brings ready up.
  task automatic push_reset();
    tbl.push_back(mkv(1'b1, 3'b000, 2'd0, 16'd0, 8'd0, 4'd0, 32'd0, 0, 0, 0, 0, 1'b0, 3'd0));
    tbl.push_back(mkv(1'b0, 3'b000, 2'd0, 16'd0, 8'd0, 4'd0, 32'd0, 0, 0, 0, 0, 1'b0, 3'd0));
  endtask

  localparam logic [2:0] H  = 3'b110;
  localparam logic [2:0] B  = 3'b100;
  localparam logic [2:0] T  = 3'b101;
  localparam logic [2:0] HT = 3'b111;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  initial begin
    logic [15:0] m [4];
    logic [3:0]  exp_rdy;
    vec_t        v;

    rst_n = 1'b0;
    f0 = '0; f100 = '0; f50 = '0;
    pl0 = '0; pl100 = '0; pl50 = '0;
    tick();
    tick();
    check("reset ready dut50", 64'(rdy50), 64'h0);
    check("reset ready dut100", 64'(rdy100), 64'h0);
    check("reset error dut100", 64'(er100), 64'h0);

    // stall 50: ready follows bit 6 of each channel's LFSR, one cycle behind.
    m[0] = 16'h01D3; m[1] = 16'h03A7; m[2] = 16'h0579; m[3] = 16'h074D;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 4) begin
        f100  = mk(H, 16'd1, 8'd1, 4'd0, 32'd0);
        pl100 = 2'd0;
      end else begin
        f100 = '0;
      end
      tick();
      for (int i = 0; i < 4; i++) exp_rdy[i] = (m[i][6:0] >= 7'd64);
      check($sformatf("ready50 c%0d", c), 64'(rdy50), 64'(exp_rdy));
      for (int i = 0; i < 4; i++) m[i] = lfsr_step(m[i]);
      if (c == 4) begin
        check("stall100 ready", 64'(rdy100), 64'h0);
        check("stall100 error", 64'(er100), 64'h1);
        check("stall100 code", 64'(ec100), 64'd6);
        check("stall100 flits", 64'(fl100), 64'd0);
      end
    end

    // Table: rows apply one per cycle; expected values are post-edge.
    push_reset();
    // Interleaved pl0 / pl3
    tbl.push_back(mkv(0, H, 0, 10, 1, 0, 0,            1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, H, 3, 11, 1, 0, 1,            2, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, B, 0, 10, 2, 0, 0,            3, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, B, 3, 11, 2, 0, 0,            4, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, T, 0, 10, 3, 0, 0,            5, 1, 5, 5, 0, 0));
    tbl.push_back(mkv(0, T, 3, 11, 3, 0, 0,            6, 2, 10, 5, 0, 0));
    // pl2 packet, latency 9 raises max
    tbl.push_back(mkv(0, H, 2, 12, 1, 0, 0,            7, 2, 10, 5, 0, 0));
    tbl.push_back(mkv(0, B, 2, 12, 2, 0, 0,            8, 2, 10, 5, 0, 0));
    tbl.push_back(mkv(0, T, 2, 12, 3, 0, 0,            9, 3, 19, 9, 0, 0));
    // pl1 packet, latency 4 leaves max
    tbl.push_back(mkv(0, H, 1, 13, 1, 0, 8,            10, 3, 19, 9, 0, 0));
    tbl.push_back(mkv(0, B, 1, 13, 2, 0, 0,            11, 3, 19, 9, 0, 0));
    tbl.push_back(mkv(0, T, 1, 13, 3, 0, 0,            12, 4, 23, 9, 0, 0));
    // inject_time after sys_time: latency wraps (15 - 0xFFFFFFF0 = 31)
    tbl.push_back(mkv(0, H, 0, 14, 1, 0, 32'hFFFF_FFF0, 13, 4, 23, 9, 0, 0));
    tbl.push_back(mkv(0, B, 0, 14, 2, 0, 0,            14, 4, 23, 9, 0, 0));
    tbl.push_back(mkv(0, T, 0, 14, 3, 0, 0,            15, 5, 54, 31, 0, 0));
    // body with no head: code 1, not counted; channel still idle
    tbl.push_back(mkv(0, B, 0, 20, 2, 0, 0,            15, 5, 54, 31, 1, 1));
    tbl.push_back(mkv(0, H, 0, 21, 1, 0, 17,           16, 5, 54, 31, 1, 1));
    tbl.push_back(mkv(0, B, 0, 21, 2, 0, 0,            17, 5, 54, 31, 1, 1));
    tbl.push_back(mkv(0, T, 0, 21, 3, 0, 0,            18, 6, 56, 31, 1, 1));
    // wrong destination: code 4
    push_reset();
    tbl.push_back(mkv(0, H, 2, 30, 1, 1, 0,            0, 0, 0, 0, 1, 4));
    // head in BODY: code 2, new head adopted and completes
    push_reset();
    tbl.push_back(mkv(0, H, 1, 40, 1, 0, 0,            1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, H, 1, 41, 1, 0, 2,            2, 0, 0, 0, 1, 2));
    tbl.push_back(mkv(0, B, 1, 41, 2, 0, 0,            3, 0, 0, 0, 1, 2));
    tbl.push_back(mkv(0, T, 1, 41, 3, 0, 0,            4, 1, 2, 2, 1, 2));
    // flit_id out of sequence: code 3, channel back to idle
    push_reset();
    tbl.push_back(mkv(0, H, 0, 50, 1, 0, 0,            1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, B, 0, 50, 3, 0, 0,            1, 0, 0, 0, 1, 3));
    tbl.push_back(mkv(0, B, 0, 50, 2, 0, 0,            1, 0, 0, 0, 1, 3));
    // packet_id change: code 5
    push_reset();
    tbl.push_back(mkv(0, H, 3, 60, 1, 0, 0,            1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, B, 3, 61, 2, 0, 0,            1, 0, 0, 0, 1, 5));
    // single-flit packet with wrong tail id: code 7
    push_reset();
    tbl.push_back(mkv(0, HT, 0, 70, 1, 0, 0,           0, 0, 0, 0, 1, 7));
    // single-flit packet with correct tail id completes in IDLE
    push_reset();
    tbl.push_back(mkv(0, HT, 0, 71, 3, 0, 0,           1, 1, 1, 1, 0, 0));
    // reset mid-packet discards it; next full packet counts alone
    push_reset();
    tbl.push_back(mkv(0, H, 1, 80, 1, 0, 0,            1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, B, 1, 80, 2, 0, 0,            2, 0, 0, 0, 0, 0));
    push_reset();
    tbl.push_back(mkv(0, H, 1, 81, 1, 0, 0,            1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, B, 1, 81, 2, 0, 0,            2, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, T, 1, 81, 3, 0, 0,            3, 1, 3, 3, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      v     = tbl[r];
      rst_n = ~v.rst;
      f0    = mk(v.vht, v.pid, v.fid, v.xd, v.inj);
      pl0   = v.pl;
      tick();
      check($sformatf("r%0d flits", r), 64'(fl0), 64'(v.e_fl));
      check($sformatf("r%0d packets", r), 64'(pk0), 64'(v.e_pk));
      check($sformatf("r%0d lat_sum", r), 64'(ls0), 64'(v.e_ls));
      check($sformatf("r%0d lat_max", r), 64'(lm0), 64'(v.e_lm));
      check($sformatf("r%0d error", r), 64'(er0), 64'(v.e_er));
      check($sformatf("r%0d code", r), 64'(ec0), 64'(v.e_ec));
      check($sformatf("r%0d ready", r), 64'(rdy0), 64'(v.e_rdy));
    end

    // pl1 packet, inject_time 5, tail accepted at sys_time 20.
    f0 = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 18; k++) tick();
    pl0 = 2'd1;
    f0 = mk(H, 16'd90, 8'd1, 4'd0, 32'd5);
    tick();
    f0 = mk(B, 16'd90, 8'd2, 4'd0, 32'd0);
    tick();
    f0 = mk(T, 16'd90, 8'd3, 4'd0, 32'd0);
    tick();
    f0 = '0;
    check("t20 packets", 64'(pk0), 64'd1);
    check("t20 flits", 64'(fl0), 64'd3);
    check("t20 lat_sum", 64'(ls0), 64'd15);
    check("t20 lat_max", 64'(lm0), 64'd15);
    check("t20 error", 64'(er0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lag_traffic_sink.md
LAG_TRAFFIC_SINK -- requirements
Module: LAG_traffic_sink

Interface
REQ-001 Parameter nv, default 4: number of physical/virtual channels on network exit.
REQ-002 Parameter xpos, default 0: mesh X coordinate of the attached router.
REQ-003 Parameter ypos, default 0: mesh Y coordinate of the attached router.
REQ-004 Parameter packet_length, default 3: expected flits per packet.
REQ-005 Parameter stall_pct, default 0: back-pressure percentage, 0..100.
REQ-006 Port clk, input, 1 bit: clock.
REQ-007 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 Port flit_in, input, flit_t: ejected flit; control.valid qualifies it.
REQ-009 Port in_pl, input, $clog2(nv) bits (minimum 1): channel index of flit_in.
REQ-010 Port ready, output, nv bits: per-channel sink-ready, registered.
REQ-011 Port packets_received, output, 32 bits: completed packets, wraps modulo 2^32.
REQ-012 Port flits_received, output, 32 bits: accepted flits, wraps modulo 2^32.
REQ-013 Port latency_sum, output, 48 bits: sum of packet latencies, wraps modulo 2^48.
REQ-014 Port latency_max, output, 32 bits: largest packet latency seen.
REQ-015 Port error, output, 1 bit: sticky error flag.
REQ-016 Port error_code, output, 3 bits: code of the first error; 0 means none.

Function
REQ-017 32-bit sys_time SHALL be 0 in the first cycle after reset and increment by 1 every cycle, matching the source's time base.
REQ-018 A flit SHALL be accepted when flit_in.control.valid=1 and ready[in_pl]=1; otherwise it is ignored for all counts.
REQ-019 A flit with valid=1 while ready[in_pl]=0 SHALL raise error code 6 and be dropped.
REQ-020 Each channel SHALL run its own FSM with states IDLE and BODY.
REQ-021 IDLE, accepted head with tail=0 -> BODY: store packet_id; expected flit_id becomes 2; store inject_time.
REQ-022 IDLE, accepted head with tail=1 -> stay IDLE; the packet completes that cycle.
REQ-023 BODY, accepted non-head flit whose flit_id equals the expected value -> expected value increments; tail=1 completes the packet and returns to IDLE.
REQ-024 Error codes SHALL be: 1 = non-head flit in IDLE; 2 = head flit in BODY; 3 = flit_id out of sequence; 4 = debug.xdest/ydest differs from xpos/ypos; 5 = packet_id changes mid-packet; 7 = tail flit_id differs from packet_length.
REQ-025 On any error the FSM SHALL return to IDLE, except code 2, where the new head is adopted as a fresh packet.
REQ-026 error SHALL go 1 on the first error; error_code SHALL latch that first code; both hold until reset.
REQ-027 Latency SHALL be sys_time at tail acceptance minus the head's inject_time, as unsigned 32-bit modular subtraction.
REQ-028 On completion: packets_received +1, latency_sum += latency, latency_max = max(latency_max, latency); all updates visible the next cycle.
REQ-029 flits_received SHALL increment once per accepted flit, one cycle after acceptance.
REQ-030 ready[i] SHALL be driven from a per-channel 16-bit maximal LFSR with seed (i+1)*0x1D3 | 1.
REQ-031 The LFSR SHALL advance every cycle; ready[i] next = (lfsr[6:0] >= stall_pct*128/100), integer arithmetic.
REQ-032 With stall_pct=0, ready SHALL be all-ones from the first cycle after reset; with stall_pct=100, ready SHALL be all-zeros.
REQ-033 Only one flit SHALL arrive per cycle; simultaneous completion and error in one cycle SHALL both be applied.

Reset
REQ-034 While rst_n=0 at a clock edge, the following SHALL be 0: ready, all counters, latency_max, error, error_code, sys_time.
REQ-035 Reset SHALL also return every FSM to IDLE and reload the LFSR seeds.
REQ-036 Reset asserted mid-packet SHALL discard the partial packet; it SHALL not be counted.

Structure
REQ-037 sink_state_t (IDLE, BODY) and sink_err_t (codes 0..7) SHALL live in the shared LAG package alongside flit_t.
REQ-038 The per-channel FSM, expected-id and packet-id registers SHALL be sub-module LAG_sink_pl_checker, instantiated nv times; the statistics logic stays in the top level.

Verification
REQ-039 stall_pct=0, one 3-flit packet on pl 1, inject_time=5, tail accepted at sys_time=20 -> packets_received=1, flits_received=3, latency_sum=15, latency_max=15, error=0.
REQ-040 Body flit on pl 0 with no preceding head -> error=1, error_code=1, flits_received unchanged, FSM remains IDLE.
REQ-041 Head on pl 2 with debug.xdest=1, xpos=0 -> error_code=4.
REQ-042 Interleaved packets on pl 0 and pl 3, flit by flit -> both complete, packets_received=2, no error.
REQ-043 stall_pct=100 with valid=1 on pl 0 -> ready=0, error_code=6, flits_received=0.
REQ-044 rst_n pulsed after the second flit of a packet, then a full 3-flit packet sent -> packets_received=1, error=0.
